// File: rtl/obi_instr_mem_responder.sv
// rtl/obi_instr_mem_responder.sv - OBI instruction memory responder with programmable grant/response timing
// Word array behind an in-order response FIFO; bus/PMP errors injectable per word address.

module obi_instr_mem_responder #(
    parameter int DEPTH_WORDS     = 1024,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   instr_req_i,
    input  logic [31:0]                            instr_addr_i,
    output logic                                   instr_gnt_o,
    output logic                                   instr_rvalid_o,
    output logic [31:0]                            instr_rdata_o,
    output logic                                   instr_err_o,
    output logic                                   instr_err_pmp_o,
    input  logic                                   load_we_i,
    input  logic [31:0]                            load_addr_i,
    input  logic [31:0]                            load_wdata_i,
    input  logic [3:0]                             gnt_delay_i,
    input  logic [3:0]                             rvalid_delay_i,
    input  logic                                   err_en_i,
    input  logic [31:0]                            err_addr_i,
    input  logic                                   pmp_en_i,
    input  logic [31:0]                            pmp_addr_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
    localparam logic [OW-1:0] FULL_CNT = OW'(MAX_OUTSTANDING);

    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   f_rdata [MAX_OUTSTANDING];
    logic          f_err   [MAX_OUTSTANDING];
    logic          f_pmp   [MAX_OUTSTANDING];
    logic [3:0]    f_cnt   [MAX_OUTSTANDING];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [OW-1:0] count;
    logic [3:0]    wait_cnt;

    logic          err_hit;
    logic          pmp_hit;
    logic [31:0]   push_rdata;
    logic          push;
    logic          pop;
    logic          unused_addr_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Array has no reset: contents survive rst_n so a bench can reset mid-program.
    always_ff @(posedge clk) begin
        if (load_we_i) begin
            mem[load_addr_i[AW+1:2]] <= load_wdata_i;
        end
    end

    assign err_hit    = err_en_i && (instr_addr_i[31:2] == err_addr_i[31:2]);
    assign pmp_hit    = pmp_en_i && (instr_addr_i[31:2] == pmp_addr_i[31:2]);
    assign push_rdata = (err_hit || pmp_hit) ? 32'h0 : mem[instr_addr_i[AW+1:2]];

    // A same-cycle pop never frees the slot for this cycle's grant.
    assign instr_gnt_o    = instr_req_i && (wait_cnt >= gnt_delay_i) && (count < FULL_CNT);
    assign instr_rvalid_o = (count != '0) && (f_cnt[rd_ptr] == 4'd0);
    assign push           = instr_gnt_o;
    assign pop            = instr_rvalid_o;

    assign instr_rdata_o   = instr_rvalid_o ? f_rdata[rd_ptr] : 32'h0;
    assign instr_err_o     = instr_rvalid_o && f_err[rd_ptr];
    assign instr_err_pmp_o = instr_rvalid_o && f_pmp[rd_ptr];
    assign outstanding_o   = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                f_rdata[i] <= 32'h0;
                f_err[i]   <= 1'b0;
                f_pmp[i]   <= 1'b0;
                f_cnt[i]   <= 4'd0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wait_cnt <= 4'd0;
        end else begin
            // Entries age in parallel; the head is only released once its own count reaches zero.
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (f_cnt[i] != 4'd0) begin
                    f_cnt[i] <= f_cnt[i] - 4'd1;
                end
            end
            if (push) begin
                f_rdata[wr_ptr] <= push_rdata;
                f_err[wr_ptr]   <= err_hit;
                f_pmp[wr_ptr]   <= pmp_hit && !err_hit;
                f_cnt[wr_ptr]   <= rvalid_delay_i;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (!instr_req_i || instr_gnt_o) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt != 4'd15) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    assign unused_addr_bits = ^{instr_addr_i[1:0], load_addr_i[31:AW+2], load_addr_i[1:0],
                                err_addr_i[1:0], pmp_addr_i[1:0]};

endmodule
